// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               RV32M/RV64M funct3 codes, FSM state encoding and the
//               signed-operand decode helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // funct3 encodings of the M-extension operations
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } mdState_e;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic isSignedA(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic isSignedB(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_negate.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_negate
// Description : Conditional two's-complement negation, W bits wide.
// Ports       : inVal  in  W  value to pass or negate
//               neg    in  1  negate when high
//               outVal out W  inVal or -inVal (mod 2^W)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] inVal,
  input  logic         neg,
  output logic [W-1:0] outVal
);

  assign outVal = neg ? (~inVal + W'(1)) : inVal;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide unit. One product or
//               quotient bit per cycle; sign handling done once up front
//               (magnitudes) and once at the end (correction).
// Ports       : clk       in  1     rising-edge clock
//               rst_n     in  1     asynchronous active-low reset
//               in_valid  in  1     operation request
//               in_ready  out 1     unit can accept (IDLE only)
//               op        in  3     funct3 operation select
//               rs1       in  XLEN  multiplicand / dividend
//               rs2       in  XLEN  multiplier / divisor
//               flush     in  1     kill any in-flight operation
//               out_valid out 1     result available
//               out_ready in  1     consumer takes result
//               result    out XLEN  operation result
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  mdState_e            r_state;
  mdState_e            w_nextState;

  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_rs1;
  logic [XLEN-1:0]     r_rs2;
  logic [XLEN-1:0]     r_a;        // multiplicand magnitude
  logic [XLEN-1:0]     r_b;        // divisor magnitude
  logic [2*XLEN-1:0]   r_acc;      // {hi, lo}: product, or {remainder, quotient}
  logic [CNT_W-1:0]    r_cnt;
  logic                r_negRes;
  logic                r_negRem;
  logic                r_special;
  logic [XLEN-1:0]     r_result;

  logic                w_accept;
  logic                w_isDiv;
  logic                w_aNeg;
  logic                w_bNeg;
  logic [XLEN-1:0]     w_aMag;
  logic [XLEN-1:0]     w_bMag;
  logic                w_divZero;
  logic                w_overflow;
  logic                w_special;
  logic [XLEN-1:0]     w_specialRes;
  logic [XLEN:0]       w_mulSum;
  logic [XLEN:0]       w_mulHi;
  logic [2*XLEN-1:0]   w_mulNext;
  logic [XLEN:0]       w_divSh;
  logic [XLEN:0]       w_divDiff;
  logic [2*XLEN-1:0]   w_divNext;
  logic [2*XLEN-1:0]   w_prodCorr;
  logic [XLEN-1:0]     w_quotCorr;
  logic [XLEN-1:0]     w_remCorr;
  logic [XLEN-1:0]     w_fixRes;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;

  // flush in IDLE suppresses the accept for that cycle
  assign w_accept  = in_valid && in_ready && !flush;

  // ---------------------------------------------------------------- PREP ---
  assign w_isDiv = r_op[2];
  assign w_aNeg  = isSignedA(r_op) && r_rs1[XLEN-1];
  assign w_bNeg  = isSignedB(r_op) && r_rs2[XLEN-1];

  muldiv_negate #(.W(XLEN)) u_negA (.inVal(r_rs1), .neg(w_aNeg), .outVal(w_aMag));
  muldiv_negate #(.W(XLEN)) u_negB (.inVal(r_rs2), .neg(w_bNeg), .outVal(w_bMag));

  assign w_divZero  = (r_rs2 == '0);
  assign w_overflow = isSignedB(r_op) && (r_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (r_rs2 == '1);
  assign w_special  = w_isDiv && (w_divZero || w_overflow);

  // op[1] distinguishes REM/REMU from DIV/DIVU
  always_comb begin
    w_specialRes = '0;
    if (w_divZero) begin
      w_specialRes = r_op[1] ? r_rs1 : '1;
    end else begin
      w_specialRes = r_op[1] ? '0 : r_rs1;
    end
  end

  // ---------------------------------------------------------------- CALC ---
  // Multiply: lo half starts as the multiplier and is shifted out LSB first
  // while partial sums accumulate into hi; the carry rides into the shift.
  assign w_mulSum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_a};
  assign w_mulHi   = r_acc[0] ? w_mulSum : {1'b0, r_acc[2*XLEN-1:XLEN]};
  assign w_mulNext = {w_mulHi, r_acc[XLEN-1:1]};

  // Divide (restoring): shift the next dividend bit into the remainder,
  // trial-subtract the divisor and shift the quotient bit into lo.
  // The remainder is always below the divisor, so the top bit of the
  // (XLEN+1)-bit difference is a reliable borrow flag.
  assign w_divSh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_divDiff = w_divSh - {1'b0, r_b};
  assign w_divNext = w_divDiff[XLEN]
                   ? {w_divSh[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0}
                   : {w_divDiff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  // ----------------------------------------------------------------- FIX ---
  muldiv_negate #(.W(2*XLEN)) u_negProd (.inVal(r_acc), .neg(r_negRes), .outVal(w_prodCorr));
  muldiv_negate #(.W(XLEN)) u_negQuot (.inVal(r_acc[XLEN-1:0]), .neg(r_negRes), .outVal(w_quotCorr));
  muldiv_negate #(.W(XLEN)) u_negRem (.inVal(r_acc[2*XLEN-1:XLEN]), .neg(r_negRem), .outVal(w_remCorr));

  always_comb begin
    w_fixRes = '0;
    if (r_special) begin
      w_fixRes = r_acc[XLEN-1:0];
    end else begin
      unique case (r_op)
        MD_MUL:                     w_fixRes = w_prodCorr[XLEN-1:0];
        MD_MULH, MD_MULHSU, MD_MULHU: w_fixRes = w_prodCorr[2*XLEN-1:XLEN];
        MD_DIV, MD_DIVU:            w_fixRes = w_quotCorr;
        default:                    w_fixRes = w_remCorr;
      endcase
    end
  end

  // ----------------------------------------------------------------- FSM ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = PREP;
      PREP:    w_nextState = w_special ? FIX : CALC;
      CALC:    if (r_cnt == CNT_W'(1)) w_nextState = FIX;
      FIX:     w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    // flush overrides everything, including a DONE handshake
    if (flush && (r_state != IDLE)) begin
      w_nextState = IDLE;
    end
  end

  // ------------------------------------------------------------ datapath ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_special <= 1'b0;
      r_result  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op  <= op;
            r_rs1 <= rs1;
            r_rs2 <= rs2;
          end
        end
        PREP: begin
          r_a       <= w_aMag;
          r_b       <= w_bMag;
          r_negRes  <= w_aNeg ^ w_bNeg;
          r_negRem  <= w_aNeg;
          r_special <= w_special;
          r_cnt     <= CNT_W'(XLEN);
          if (w_special) begin
            r_acc <= {{XLEN{1'b0}}, w_specialRes};
          end else begin
            r_acc <= {{XLEN{1'b0}}, (w_isDiv ? w_aMag : w_bMag)};
          end
        end
        CALC: begin
          r_acc <= w_isDiv ? w_divNext : w_mulNext;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          r_result <= w_fixRes;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit, XLEN=32 and
//               XLEN=64 instances driven from one clock.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;

  logic        inValid32, inReady32, outValid32, outReady32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;

  logic        inValid64, inReady64, outValid64, outReady64;
  logic [2:0]  op64;
  logic [63:0] a64, b64, res64;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid32), .in_ready(inReady32),
    .op(op32), .rs1(a32), .rs2(b32), .flush(flush),
    .out_valid(outValid32), .out_ready(outReady32), .result(res32)
  );

  muldiv_unit #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid64), .in_ready(inReady64),
    .op(op64), .rs1(a64), .rs2(b64), .flush(flush),
    .out_valid(outValid64), .out_ready(outReady64), .result(res64)
  );

  // --- drivers (no checking inside) ---
  task automatic startOp32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    while (!inReady32 && guard < 200) begin @(posedge clk); #1; guard++; end
    op32 = o; a32 = a; b32 = b; inValid32 = 1'b1;
    @(posedge clk); #1;   // accept edge 0
    inValid32 = 1'b0;
  endtask

  task automatic waitDone32(output int lat);
    lat = 0;
    while (!outValid32 && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume32();
    outReady32 = 1'b1;
    @(posedge clk); #1;
    outReady32 = 1'b0;
  endtask

  task automatic startOp64(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    int guard = 0;
    while (!inReady64 && guard < 200) begin @(posedge clk); #1; guard++; end
    op64 = o; a64 = a; b64 = b; inValid64 = 1'b1;
    @(posedge clk); #1;
    inValid64 = 1'b0;
  endtask

  task automatic waitDone64(output int lat);
    lat = 0;
    while (!outValid64 && lat < 300) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic consume64();
    outReady64 = 1'b1;
    @(posedge clk); #1;
    outReady64 = 1'b0;
  endtask

  // --- scenarios ---
  task automatic test_reset();
    checks++; if (outValid32 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", outValid32); end
    checks++; if (res32 !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", res32); end
    checks++; if (inReady32 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", inReady32); end
    checks++; if (inReady64 !== 1'b1) begin errors++; $display("FAIL reset_in_ready64 got %0b want 1", inReady64); end
  endtask

  task automatic test_mul();
    int lat;
    startOp32(MD_MUL, 32'd7, 32'hFFFFFFFD); waitDone32(lat);
    checks++; if (res32 !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul got %h want ffffffeb", res32); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got %0d want 34", lat); end
    consume32();
    startOp32(MD_MULH, 32'h80000000, 32'h80000000); waitDone32(lat);
    checks++; if (res32 !== 32'h40000000) begin errors++; $display("FAIL mulh got %h want 40000000", res32); end
    consume32();
    startOp32(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF); waitDone32(lat);
    checks++; if (res32 !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", res32); end
    consume32();
    startOp32(MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF); waitDone32(lat);
    checks++; if (res32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu got %h want ffffffff", res32); end
    consume32();
    startOp32(MD_MULH, 32'hFFFFFFFD, 32'd5); waitDone32(lat);   // -15 -> high word all ones
    checks++; if (res32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulh_neg got %h want ffffffff", res32); end
    consume32();
  endtask

  task automatic test_div();
    int lat;
    startOp32(MD_DIV, 32'hFFFFFFF9, 32'd2); waitDone32(lat);
    checks++; if (res32 !== 32'hFFFFFFFD) begin errors++; $display("FAIL div got %h want fffffffd", res32); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
    consume32();
    startOp32(MD_REM, 32'hFFFFFFF9, 32'd2); waitDone32(lat);
    checks++; if (res32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem got %h want ffffffff", res32); end
    consume32();
    startOp32(MD_DIVU, 32'd100, 32'd7); waitDone32(lat);
    checks++; if (res32 !== 32'd14) begin errors++; $display("FAIL divu got %h want 0000000e", res32); end
    consume32();
    startOp32(MD_REMU, 32'd100, 32'd7); waitDone32(lat);
    checks++; if (res32 !== 32'd2) begin errors++; $display("FAIL remu got %h want 00000002", res32); end
    consume32();
    startOp32(MD_REM, 32'd7, 32'hFFFFFFFE); waitDone32(lat);    // 7 rem -2 = 1
    checks++; if (res32 !== 32'd1) begin errors++; $display("FAIL rem_pos got %h want 00000001", res32); end
    consume32();
  endtask

  task automatic test_div_special();
    int lat;
    startOp32(MD_DIV, 32'd5, 32'd0); waitDone32(lat);
    checks++; if (res32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0 got %h want ffffffff", res32); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL div0_latency got %0d want 2", lat); end
    consume32();
    startOp32(MD_REM, 32'd5, 32'd0); waitDone32(lat);
    checks++; if (res32 !== 32'd5) begin errors++; $display("FAIL rem0 got %h want 00000005", res32); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL rem0_latency got %0d want 2", lat); end
    consume32();
    startOp32(MD_DIV, 32'h80000000, 32'hFFFFFFFF); waitDone32(lat);
    checks++; if (res32 !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h want 80000000", res32); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL div_ovf_latency got %0d want 2", lat); end
    consume32();
    startOp32(MD_REM, 32'h80000000, 32'hFFFFFFFF); waitDone32(lat);
    checks++; if (res32 !== 32'h0) begin errors++; $display("FAIL rem_ovf got %h want 0", res32); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL rem_ovf_latency got %0d want 2", lat); end
    consume32();
    // unsigned divide of the same operands is a normal operation: 0x80000000 / 0xFFFFFFFF = 0
    startOp32(MD_DIVU, 32'h80000000, 32'hFFFFFFFF); waitDone32(lat);
    checks++; if (res32 !== 32'h0) begin errors++; $display("FAIL divu_noovf got %h want 0", res32); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_noovf_latency got %0d want 34", lat); end
    consume32();
  endtask

  task automatic test_back_to_back();
    int lat;
    startOp32(MD_MUL, 32'd3, 32'd5); waitDone32(lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (outValid32 !== 1'b1) begin errors++; $display("FAIL hold_out_valid cyc %0d got %0b want 1", i, outValid32); end
      checks++; if (res32 !== 32'd15) begin errors++; $display("FAIL hold_result cyc %0d got %h want 0000000f", i, res32); end
      checks++; if (inReady32 !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %0b want 0", i, inReady32); end
      @(posedge clk); #1;
    end
    consume32();
    checks++; if (outValid32 !== 1'b0) begin errors++; $display("FAIL post_hs_out_valid got %0b want 0", outValid32); end
    checks++; if (inReady32 !== 1'b1) begin errors++; $display("FAIL post_hs_in_ready got %0b want 1", inReady32); end
    op32 = MD_DIVU; a32 = 32'd100; b32 = 32'd7; inValid32 = 1'b1;
    @(posedge clk); #1;
    inValid32 = 1'b0;
    checks++; if (inReady32 !== 1'b0) begin errors++; $display("FAIL b2b_accept in_ready got %0b want 0", inReady32); end
    waitDone32(lat);
    checks++; if (res32 !== 32'd14) begin errors++; $display("FAIL b2b_result got %h want 0000000e", res32); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_latency got %0d want 34", lat); end
    consume32();
  endtask

  task automatic test_flush();
    int seen = 0;
    startOp32(MD_DIV, 32'd1000, 32'd3);
    repeat (11) begin @(posedge clk); #1; end   // edge 1 enters CALC, edges 2..11 are CALC cycles
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (inReady32 !== 1'b1) begin errors++; $display("FAIL flush_idle in_ready got %0b want 1", inReady32); end
    checks++; if (outValid32 !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b want 0", outValid32); end
    for (int i = 0; i < 40; i++) begin
      if (outValid32 === 1'b1) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_result got %0d valid cycles want 0", seen); end
    checks++; if (res32 !== 32'd14) begin errors++; $display("FAIL flush_result_held got %h want 0000000e", res32); end
    // flush in IDLE blocks the accept
    op32 = MD_MUL; a32 = 32'd2; b32 = 32'd2; inValid32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    inValid32 = 1'b0; flush = 1'b0;
    checks++; if (inReady32 !== 1'b1) begin errors++; $display("FAIL flush_blocks_accept in_ready got %0b want 1", inReady32); end
  endtask

  task automatic test_async_reset();
    startOp32(MD_MUL, 32'd7, 32'd9);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++; if (outValid32 !== 1'b0) begin errors++; $display("FAIL async_rst_out_valid got %0b want 0", outValid32); end
    checks++; if (res32 !== 32'h0) begin errors++; $display("FAIL async_rst_result got %h want 0", res32); end
    checks++; if (inReady32 !== 1'b1) begin errors++; $display("FAIL async_rst_in_ready got %0b want 1", inReady32); end
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_xlen64();
    int lat;
    startOp64(MD_MUL, 64'hFFFFFFFFFFFFFFFF, 64'd2); waitDone64(lat);
    checks++; if (res64 !== 64'hFFFFFFFFFFFFFFFE) begin errors++; $display("FAIL mul64 got %h want fffffffffffffffe", res64); end
    checks++; if (lat !== 66) begin errors++; $display("FAIL mul64_latency got %0d want 66", lat); end
    consume64();
    startOp64(MD_DIVU, 64'h8000000000000000, 64'd3); waitDone64(lat);
    checks++; if (res64 !== 64'h2AAAAAAAAAAAAAAA) begin errors++; $display("FAIL divu64 got %h want 2aaaaaaaaaaaaaaa", res64); end
    consume64();
    startOp64(MD_REMU, 64'h8000000000000000, 64'd3); waitDone64(lat);
    checks++; if (res64 !== 64'd2) begin errors++; $display("FAIL remu64 got %h want 2", res64); end
    consume64();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    inValid32 = 1'b0; outReady32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    inValid64 = 1'b0; outReady64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_xlen64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
